// File: rtl/hazard_controller.sv
// hazard_controller: interlock and forwarding control for the 5-stage RV32I pipe.
// Tracks the EX/MEM/WB instructions as small records and, from the decoded ID
// instruction, produces PC/IF-ID enables, flush/bubble controls, registered EX
// operand forwarding selects and a stall-cycle counter.
// Configuration macro: HAZARD_FORWARDING_EN (defined = forwarding with load-use
// interlock only; undefined = full RAW interlock on EX and MEM, no forwarding).

`ifndef NOTLOAD
`define NOTLOAD   3'b000
`endif
`ifndef NOTSTORE
`define NOTSTORE  2'b00
`endif
`ifndef NOTBRANCH
`define NOTBRANCH 3'b000
`endif
`ifndef Beq
`define Beq       3'b001
`endif
`ifndef Bne
`define Bne       3'b010
`endif
`ifndef Blt
`define Blt       3'b011
`endif
`ifndef Bge
`define Bge       3'b100
`endif
`ifndef Bltu
`define Bltu      3'b101
`endif
`ifndef Bgeu
`define Bgeu      3'b110
`endif

module hazard_controller #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            id_valid,
   input  logic [4:0]      srcreg1_num,
   input  logic [4:0]      srcreg2_num,
   input  logic [4:0]      dstreg_num,
   input  logic            using_r2,
   input  logic            write_reg,
   input  logic [2:0]      info_load,
   input  logic [1:0]      info_store,
   input  logic [2:0]      info_branch,
   input  logic            ex_redirect,
   input  logic            mem_stall,
   output logic            pc_we,
   output logic            ifid_we,
   output logic            flush_if,
   output logic            bubble_ex,
   output logic [1:0]      fwd_a_sel,
   output logic [1:0]      fwd_b_sel,
   output logic [XLEN-1:0] stall_count
);

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       wr;
      logic       ld;
   } stage_rec_t;

   stage_rec_t      ex_rec_r, mem_rec_r, wb_rec_r;
   stage_rec_t      ex_next_s;
   logic [1:0]      fwd_a_r, fwd_b_r;
   logic [1:0]      fwd_a_next_s, fwd_b_next_s;
   logic [XLEN-1:0] stall_count_r;

   logic br_cmp_s, rs1_used_s, rs2_used_s;
   logic ex_hit1_s, ex_hit2_s, mem_hit1_s, mem_hit2_s;
   logic hazard_s, issue_s, count_inc_s;
   logic pc_we_s, ifid_we_s, flush_if_s, bubble_ex_s;
   logic unused_s;

   // A record produces register r when it is live, writes, and r is not x0
   function automatic logic rec_match(input stage_rec_t rec, input logic [4:0] r);
      return rec.valid & rec.wr & (rec.rd == r) & (rec.rd != 5'd0);
   endfunction

   // Conditional branches are the only branch class that reads rs2
   always_comb begin
      br_cmp_s = 1'b0;
      case (info_branch)
         `Beq, `Bne, `Blt, `Bge, `Bltu, `Bgeu: br_cmp_s = 1'b1;
         default:                              br_cmp_s = 1'b0;
      endcase
   end

   assign rs1_used_s = (srcreg1_num != 5'd0);
   assign rs2_used_s = (srcreg2_num != 5'd0) &
                       (using_r2 | (info_store != `NOTSTORE) | br_cmp_s);

   assign ex_hit1_s  = rs1_used_s & rec_match(ex_rec_r,  srcreg1_num);
   assign ex_hit2_s  = rs2_used_s & rec_match(ex_rec_r,  srcreg2_num);
   assign mem_hit1_s = rs1_used_s & rec_match(mem_rec_r, srcreg1_num);
   assign mem_hit2_s = rs2_used_s & rec_match(mem_rec_r, srcreg2_num);

   // WB writes the register file before ID reads it, so WB never needs a check
   assign unused_s = ^{wb_rec_r, mem_rec_r.ld};

   assign issue_s   = id_valid & ~bubble_ex_s;
   assign ex_next_s = {issue_s, dstreg_num, write_reg, (info_load != `NOTLOAD)};

`ifdef HAZARD_FORWARDING_EN
   // EX producer wins over MEM because it is the younger value
   function automatic logic [1:0] fwd_pick(input logic ex_hit, input logic mem_hit);
      logic [1:0] sel;
      if (ex_hit) begin
         sel = 2'b01;
      end else if (mem_hit) begin
         sel = 2'b10;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   assign hazard_s     = ex_rec_r.ld & (ex_hit1_s | ex_hit2_s);
   assign fwd_a_next_s = issue_s ? fwd_pick(ex_hit1_s, mem_hit1_s) : 2'b00;
   assign fwd_b_next_s = issue_s ? fwd_pick(ex_hit2_s, mem_hit2_s) : 2'b00;
`else
   assign hazard_s     = ex_hit1_s | ex_hit2_s | mem_hit1_s | mem_hit2_s;
   assign fwd_a_next_s = 2'b00;
   assign fwd_b_next_s = 2'b00;
`endif

   // Prioritised pipe control: reset, memory freeze, redirect, interlock, run
   always_comb begin
      pc_we_s     = 1'b1;
      ifid_we_s   = 1'b1;
      flush_if_s  = 1'b0;
      bubble_ex_s = 1'b0;
      count_inc_s = 1'b0;
      if (!rst_n) begin
         pc_we_s     = 1'b1;
         ifid_we_s   = 1'b1;
      end else if (mem_stall) begin
         pc_we_s     = 1'b0;
         ifid_we_s   = 1'b0;
      end else if (ex_redirect) begin
         flush_if_s  = 1'b1;
         bubble_ex_s = 1'b1;
      end else if (hazard_s & id_valid) begin
         pc_we_s     = 1'b0;
         ifid_we_s   = 1'b0;
         bubble_ex_s = 1'b1;
         count_inc_s = 1'b1;
      end else begin
         pc_we_s     = 1'b1;
         ifid_we_s   = 1'b1;
      end
   end

   // Record advance, issue-time forwarding selects and saturating stall counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_rec_r      <= '0;
         mem_rec_r     <= '0;
         wb_rec_r      <= '0;
         fwd_a_r       <= 2'b00;
         fwd_b_r       <= 2'b00;
         stall_count_r <= {XLEN{1'b0}};
      end else if (!mem_stall) begin
         wb_rec_r  <= mem_rec_r;
         mem_rec_r <= ex_rec_r;
         ex_rec_r  <= ex_next_s;
         fwd_a_r   <= fwd_a_next_s;
         fwd_b_r   <= fwd_b_next_s;
         if (count_inc_s && (stall_count_r != {XLEN{1'b1}})) begin
            stall_count_r <= stall_count_r + {{(XLEN-1){1'b0}}, 1'b1};
         end else begin
            stall_count_r <= stall_count_r;
         end
      end else begin
         ex_rec_r      <= ex_rec_r;
         mem_rec_r     <= mem_rec_r;
         wb_rec_r      <= wb_rec_r;
         fwd_a_r       <= fwd_a_r;
         fwd_b_r       <= fwd_b_r;
         stall_count_r <= stall_count_r;
      end
   end

   assign pc_we       = pc_we_s;
   assign ifid_we     = ifid_we_s;
   assign flush_if    = flush_if_s;
   assign bubble_ex   = bubble_ex_s;
   assign fwd_a_sel   = fwd_a_r;
   assign fwd_b_sel   = fwd_b_r;
   assign stall_count = stall_count_r;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller. Expected control/forwarding/count
// values are queued as each ID cycle is driven and compared when the DUT shows
// them: controls at the following falling edge, registered outputs after the
// rising edge. Expectations follow HAZARD_FORWARDING_EN when it is defined.

`ifndef NOTLOAD
`define NOTLOAD   3'b000
`endif
`ifndef NOTSTORE
`define NOTSTORE  2'b00
`endif
`ifndef NOTBRANCH
`define NOTBRANCH 3'b000
`endif
`ifndef Beq
`define Beq       3'b001
`endif

module tb_hazard_controller;

   localparam int XLEN = 32;

   localparam logic [3:0] RUN    = 4'b1100;  // {pc_we, ifid_we, flush_if, bubble_ex}
   localparam logic [3:0] STALL  = 4'b0001;
   localparam logic [3:0] REDIR  = 4'b1111;
   localparam logic [3:0] FREEZE = 4'b0000;

   localparam logic [2:0] LD_N  = `NOTLOAD;
   localparam logic [2:0] LD_LW = 3'b010;
   localparam logic [1:0] ST_N  = `NOTSTORE;
   localparam logic [1:0] ST_SW = 2'b10;
   localparam logic [2:0] BR_N  = `NOTBRANCH;
   localparam logic [2:0] BR_EQ = `Beq;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            id_valid;
   logic [4:0]      srcreg1_num, srcreg2_num, dstreg_num;
   logic            using_r2, write_reg;
   logic [2:0]      info_load;
   logic [1:0]      info_store;
   logic [2:0]      info_branch;
   logic            ex_redirect, mem_stall;
   logic            pc_we, ifid_we, flush_if, bubble_ex;
   logic [1:0]      fwd_a_sel, fwd_b_sel;
   logic [XLEN-1:0] stall_count;

   typedef struct {
      string           tag;
      logic [3:0]      ctl;
      logic [1:0]      fa;
      logic [1:0]      fb;
      logic [XLEN-1:0] cnt;
   } exp_t;

   exp_t            sb_q[$];
   int              n_cmp = 0;
   int              n_err = 0;
   logic [XLEN-1:0] exp_cnt = '0;

   hazard_controller #(.XLEN(XLEN)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .srcreg1_num(srcreg1_num), .srcreg2_num(srcreg2_num), .dstreg_num(dstreg_num),
      .using_r2(using_r2), .write_reg(write_reg),
      .info_load(info_load), .info_store(info_store), .info_branch(info_branch),
      .ex_redirect(ex_redirect), .mem_stall(mem_stall),
      .pc_we(pc_we), .ifid_we(ifid_we), .flush_if(flush_if), .bubble_ex(bubble_ex),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic ur2, input logic wr,
                         input logic [2:0] ld, input logic [1:0] st, input logic [2:0] br);
      id_valid    = v;
      srcreg1_num = r1;
      srcreg2_num = r2;
      dstreg_num  = rd;
      using_r2    = ur2;
      write_reg   = wr;
      info_load   = ld;
      info_store  = st;
      info_branch = br;
   endtask

   task automatic nop();
      set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, LD_N, ST_N, BR_N);
   endtask

   // One pipeline cycle: queue expectations, compare controls, then registers
   task automatic step(input string tag, input logic [3:0] ctl,
                       input logic [1:0] fa, input logic [1:0] fb, input bit inc);
      exp_t e;
      if (inc) exp_cnt = exp_cnt + 1;
      e.tag = tag; e.ctl = ctl; e.fa = fa; e.fb = fb; e.cnt = exp_cnt;
      sb_q.push_back(e);
      @(negedge clk);
      check_eq({sb_q[0].tag, ".ctl"}, {60'd0, pc_we, ifid_we, flush_if, bubble_ex},
               {60'd0, sb_q[0].ctl});
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check_eq({e.tag, ".fwd_a"}, {62'd0, fwd_a_sel}, {62'd0, e.fa});
      check_eq({e.tag, ".fwd_b"}, {62'd0, fwd_b_sel}, {62'd0, e.fb});
      check_eq({e.tag, ".count"}, {32'd0, stall_count}, {32'd0, e.cnt});
   endtask

   task automatic drain(input int n);
      nop();
      for (int i = 0; i < n; i++) step("drain", RUN, 2'b00, 2'b00, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; ex_redirect = 1'b0; mem_stall = 1'b0;
      nop();
      #2;
      check_eq("rst.ctl", {60'd0, pc_we, ifid_we, flush_if, bubble_ex}, {60'd0, RUN});
      check_eq("rst.fwd", {60'd0, fwd_a_sel, fwd_b_sel}, 64'd0);
      check_eq("rst.count", {32'd0, stall_count}, 64'd0);
      mem_stall = 1'b1; ex_redirect = 1'b1;
      #1;
      check_eq("rst.ctl_ignores_inputs", {60'd0, pc_we, ifid_we, flush_if, bubble_ex},
               {60'd0, RUN});
      mem_stall = 1'b0; ex_redirect = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // ADD x12 <- x10,x11 then SUB reading x12 as rs1
      set_id(1'b1, 5'd10, 5'd11, 5'd12, 1'b1, 1'b1, LD_N, ST_N, BR_N);
      step("add_issue", RUN, 2'b00, 2'b00, 1'b0);
      set_id(1'b1, 5'd12, 5'd10, 5'd14, 1'b1, 1'b1, LD_N, ST_N, BR_N);
`ifdef HAZARD_FORWARDING_EN
      step("sub_fwd", RUN, 2'b01, 2'b00, 1'b0);
`else
      step("sub_stall1", STALL, 2'b00, 2'b00, 1'b1);
      step("sub_stall2", STALL, 2'b00, 2'b00, 1'b1);
      step("sub_issue", RUN, 2'b00, 2'b00, 1'b0);
`endif
      drain(3);

      // LW x13 then ADD reading x13 as rs2 (load-use)
      set_id(1'b1, 5'd1, 5'd0, 5'd13, 1'b0, 1'b1, LD_LW, ST_N, BR_N);
      step("lw_issue", RUN, 2'b00, 2'b00, 1'b0);
      set_id(1'b1, 5'd2, 5'd13, 5'd15, 1'b1, 1'b1, LD_N, ST_N, BR_N);
      step("lu_stall", STALL, 2'b00, 2'b00, 1'b1);
`ifdef HAZARD_FORWARDING_EN
      step("lu_issue", RUN, 2'b00, 2'b10, 1'b0);
`else
      step("lu_stall2", STALL, 2'b00, 2'b00, 1'b1);
      step("lu_issue", RUN, 2'b00, 2'b00, 1'b0);
`endif
      drain(3);

      // LUI x11 then SW with rs2 = x11
      set_id(1'b1, 5'd0, 5'd0, 5'd11, 1'b0, 1'b1, LD_N, ST_N, BR_N);
      step("lui_issue", RUN, 2'b00, 2'b00, 1'b0);
      set_id(1'b1, 5'd2, 5'd11, 5'd0, 1'b0, 1'b0, LD_N, ST_SW, BR_N);
`ifdef HAZARD_FORWARDING_EN
      step("sw_fwd", RUN, 2'b00, 2'b01, 1'b0);
`else
      step("sw_stall1", STALL, 2'b00, 2'b00, 1'b1);
      step("sw_stall2", STALL, 2'b00, 2'b00, 1'b1);
      step("sw_issue", RUN, 2'b00, 2'b00, 1'b0);
`endif
      drain(3);

      // LUI x11 then ADDI whose unused rs2 field is 11: no dependency
      set_id(1'b1, 5'd0, 5'd0, 5'd11, 1'b0, 1'b1, LD_N, ST_N, BR_N);
      step("lui2_issue", RUN, 2'b00, 2'b00, 1'b0);
      set_id(1'b1, 5'd3, 5'd11, 5'd5, 1'b0, 1'b1, LD_N, ST_N, BR_N);
      step("addi_nodep", RUN, 2'b00, 2'b00, 1'b0);
      drain(3);

      // LUI x11 then BEQ x0,x11: conditional branch reads rs2
      set_id(1'b1, 5'd0, 5'd0, 5'd11, 1'b0, 1'b1, LD_N, ST_N, BR_N);
      step("lui3_issue", RUN, 2'b00, 2'b00, 1'b0);
      set_id(1'b1, 5'd0, 5'd11, 5'd0, 1'b0, 1'b0, LD_N, ST_N, BR_EQ);
`ifdef HAZARD_FORWARDING_EN
      step("beq_fwd", RUN, 2'b00, 2'b01, 1'b0);
`else
      step("beq_stall1", STALL, 2'b00, 2'b00, 1'b1);
      step("beq_stall2", STALL, 2'b00, 2'b00, 1'b1);
      step("beq_issue", RUN, 2'b00, 2'b00, 1'b0);
`endif
      drain(3);

      // Redirect in the same cycle as a load-use hazard
      set_id(1'b1, 5'd1, 5'd0, 5'd13, 1'b0, 1'b1, LD_LW, ST_N, BR_N);
      step("lw2_issue", RUN, 2'b00, 2'b00, 1'b0);
      set_id(1'b1, 5'd13, 5'd0, 5'd16, 1'b0, 1'b1, LD_N, ST_N, BR_N);
      ex_redirect = 1'b1;
      step("redir_vs_hazard", REDIR, 2'b00, 2'b00, 1'b0);
      ex_redirect = 1'b0;
      drain(3);

      // Memory freeze with a load-use hazard pending and a redirect asserted
      set_id(1'b1, 5'd1, 5'd0, 5'd13, 1'b0, 1'b1, LD_LW, ST_N, BR_N);
      step("lw3_issue", RUN, 2'b00, 2'b00, 1'b0);
      set_id(1'b1, 5'd2, 5'd13, 5'd17, 1'b1, 1'b1, LD_N, ST_N, BR_N);
      mem_stall = 1'b1; ex_redirect = 1'b1;
      for (int i = 0; i < 3; i++) step("freeze", FREEZE, 2'b00, 2'b00, 1'b0);
      mem_stall = 1'b0; ex_redirect = 1'b0;
      step("thaw_stall", STALL, 2'b00, 2'b00, 1'b1);
`ifdef HAZARD_FORWARDING_EN
      step("thaw_issue", RUN, 2'b00, 2'b10, 1'b0);
`else
      step("thaw_stall2", STALL, 2'b00, 2'b00, 1'b1);
      step("thaw_issue", RUN, 2'b00, 2'b00, 1'b0);
`endif
      drain(3);

      // Load into x0 never creates a dependency
      set_id(1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1, LD_LW, ST_N, BR_N);
      step("lw_x0_issue", RUN, 2'b00, 2'b00, 1'b0);
      set_id(1'b1, 5'd0, 5'd0, 5'd18, 1'b1, 1'b1, LD_N, ST_N, BR_N);
      step("x0_nostall", RUN, 2'b00, 2'b00, 1'b0);
      drain(3);

      // Asynchronous reset in the middle of a load-use stall
      set_id(1'b1, 5'd1, 5'd0, 5'd13, 1'b0, 1'b1, LD_LW, ST_N, BR_N);
      step("lw4_issue", RUN, 2'b00, 2'b00, 1'b0);
      set_id(1'b1, 5'd13, 5'd0, 5'd19, 1'b0, 1'b1, LD_N, ST_N, BR_N);
      @(negedge clk);
      check_eq("pre_rst.ctl", {60'd0, pc_we, ifid_we, flush_if, bubble_ex}, {60'd0, STALL});
      #2 rst_n = 1'b0;
      #1;
      check_eq("mid_rst.ctl", {60'd0, pc_we, ifid_we, flush_if, bubble_ex}, {60'd0, RUN});
      check_eq("mid_rst.fwd", {60'd0, fwd_a_sel, fwd_b_sel}, 64'd0);
      check_eq("mid_rst.count", {32'd0, stall_count}, 64'd0);
      exp_cnt = '0;
      nop();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      set_id(1'b1, 5'd13, 5'd0, 5'd19, 1'b0, 1'b1, LD_N, ST_N, BR_N);
      step("post_rst_issue", RUN, 2'b00, 2'b00, 1'b0);
      drain(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard and interlock controller for the 5-stage RV32I core (IF, ID, EX, MEM, WB). It takes the decoded fields of the instruction in ID and keeps its own record of the instructions in EX, MEM and WB. From these it drives the PC/IF-ID write enables, bubble and flush controls, and the registered forwarding selects for the EX operand muxes. It sits beside `decoder` and sequences issue from ID to EX.

## Interface
Parameters:
- `XLEN`, 32: width of the stall performance counter.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `id_valid` in 1: ID holds a real instruction.
- `srcreg1_num`, `srcreg2_num`, `dstreg_num` in 5 each: decoder fields for the ID instruction.
- `using_r2`, `write_reg` in 1 each: decoder flags.
- `info_load` in 3, `info_store` in 2, `info_branch` in 3: decoder class codes (`define` values).
- `ex_redirect` in 1: the instruction in EX resolved as a taken branch, JAL or JALR.
- `mem_stall` in 1: data memory is not ready; the whole pipe must freeze.
- `pc_we` out 1: PC register write enable.
- `ifid_we` out 1: IF/ID register write enable.
- `flush_if` out 1: load a NOP into IF/ID.
- `bubble_ex` out 1: load a bubble into ID/EX instead of the ID instruction.
- `fwd_a_sel`, `fwd_b_sel` out 2 each, registered: EX operand source. 00 = register file, 01 = MEM-stage ALU result, 10 = WB-stage result.
- `stall_count` out XLEN: number of cycles in which the ID instruction was held.

## Operation
- Stage records for EX, MEM and WB: `{valid, rd[4:0], wr, ld}`. `ld` is set when `info_load` != `NOTLOAD`.
- Operand usage for the ID instruction:
  - rs1 is used when `srcreg1_num` != 0.
  - rs2 is used when `srcreg2_num` != 0 and any of: `using_r2`; `info_store` != `NOTSTORE`; `info_branch` is one of `Beq`/`Bne`/`Blt`/`Bge`/`Bltu`/`Bgeu`.
- A record matches register r when `valid & wr & (rd == r) & (rd != 0)`.
- The register file writes before it reads in the same cycle, so a match against the WB record never causes a hazard.
- `hazard` (definition depends on the configuration macro) means: hold the ID instruction and issue a bubble.
- Control priority, highest first:
  1. `mem_stall`: `pc_we`=0, `ifid_we`=0, `bubble_ex`=0, `flush_if`=0. All records and `fwd_*` hold. `ex_redirect` is ignored; EX holds and re-asserts it.
  2. `ex_redirect`: `flush_if`=1, `bubble_ex`=1, `pc_we`=1, `ifid_we`=1. Any hazard is dropped because the ID instruction is squashed.
  3. `hazard & id_valid`: `pc_we`=0, `ifid_we`=0, `bubble_ex`=1. `stall_count` increments, saturating at all-ones.
  4. Otherwise: `pc_we`=1, `ifid_we`=1, no flush, no bubble.
- Record advance on every edge without `mem_stall`: WB ← MEM, MEM ← EX.
  - EX ← `{id_valid & !bubble_ex, dstreg_num, write_reg, ld}`.
  - On bubble, EX.valid is 0.

## Timing
- All control outputs are combinational from the inputs and the records, and are valid in the same cycle. `fwd_*` and `stall_count` are registered.
- `fwd_a_sel`/`fwd_b_sel` are computed at issue from the ID operands and update on the same edge that loads ID/EX:
  - 01 if the EX record matches (that instruction moves to MEM).
  - Otherwise 10 if the MEM record matches.
  - Otherwise 00.
  - A bubble loads 00.
- Load-use hazard costs 1 cycle; a redirect costs 2 squashed slots.
- Reset (asynchronous, also mid-operation) values:
  - All records invalid.
  - `fwd_*` = 00, `stall_count` = 0.
  - `pc_we` = 1, `ifid_we` = 1, `flush_if` = 0, `bubble_ex` = 0.
- Same-cycle `ex_redirect` and hazard: the redirect wins and `stall_count` does not increment.

## Configuration
- `HAZARD_FORWARDING_EN` defined:
  - `hazard` = a used operand matches the EX record with `ld` = 1 (load-use only).
  - Forwarding operates as described under Timing.
- Not defined:
  - `hazard` = a used operand matches the EX or the MEM record, whether or not it is a load.
  - `fwd_*` is tied to 00.
  - Maximum RAW stall is 2 cycles.

## Test plan
- ADD x12←x10,x11 in EX; ID holds SUB reading x12 → no stall; next cycle `fwd_a_sel`=01. Without the macro: 2 stall cycles and `stall_count`=2.
- LW x13 in EX; ID holds ADD reading x13 as rs2 → 1 cycle with `pc_we`=0 and `bubble_ex`=1; then issue with `fwd_b_sel`=10; `stall_count`=1.
- LUI x11 in EX; ID holds SW with rs2 = x11 → forward on b (`fwd_b_sel`=01). The same case with an ADDI reading rs2 field = 11 → no dependency (rs2 unused).
- `ex_redirect`=1 in the same cycle as a load-use hazard → `flush_if`=1, `bubble_ex`=1, `pc_we`=1, `stall_count` unchanged.
- `mem_stall`=1 for 3 cycles with a hazard pending → all enables 0, records and `fwd_*` frozen; normal resolution resumes after the freeze.
- Assert `rst_n`=0 mid-stall → outputs return to reset values immediately, without waiting for a clock edge. A write to x0 in EX never stalls.
